stopwatch_mmss: RTL and testbench

STOPWATCH_MMSS -- requirements
Module: stopwatch_mmss

---
 rtl/stopwatch_mmss_if.sv | 24 ++
 rtl/stopwatch_mmss.sv | 102 ++++++++++
 tb/tb_stopwatch_mmss.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_mmss_if.sv
// Stopwatch pulse inputs and display outputs.
// master drives the one-clk pulses, slave is the stopwatch core.
interface stopwatch_mmss_if;
    logic       clk_sec;
    logic       btn_start;
    logic       btn_lap;
    logic       btn_clear;
    logic [3:0] min10;
    logic [3:0] min1;
    logic [3:0] sec10;
    logic [3:0] sec1;
    logic       running;
    logic       lap_active;

    modport master (
        output clk_sec, btn_start, btn_lap, btn_clear,
        input  min10, min1, sec10, sec1, running, lap_active
    );

    modport slave (
        input  clk_sec, btn_start, btn_lap, btn_clear,
        output min10, min1, sec10, sec1, running, lap_active
    );
endinterface

// File: rtl/stopwatch_mmss.sv
// mm:ss BCD stopwatch with run/pause/clear FSM and a lap (display freeze) capture.
// Display digits are registered one clk behind the live count or the lap value.
module stopwatch_mmss #(
    parameter bit WRAP_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    stopwatch_mmss_if.slave  sw
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    typedef struct packed {
        logic [3:0] m10;
        logic [3:0] m1;
        logic [3:0] s10;
        logic [3:0] s1;
    } mmss_t;

    state_t state;
    mmss_t  cnt, lap, disp, cnt_inc;
    logic   running, lap_active;
    logic   tick, at_max;

    assign tick   = sw.clk_sec && (state == RUN);
    assign at_max = (cnt.m10 == 4'd5) && (cnt.m1 == 4'd9) &&
                    (cnt.s10 == 4'd5) && (cnt.s1 == 4'd9);

    // BCD ripple carry; 59:59 rolls to 00:00 naturally
    always_comb begin
        cnt_inc = cnt;
        if (cnt.s1 != 4'd9) begin
            cnt_inc.s1 = cnt.s1 + 4'd1;
        end else begin
            cnt_inc.s1 = 4'd0;
            if (cnt.s10 != 4'd5) begin
                cnt_inc.s10 = cnt.s10 + 4'd1;
            end else begin
                cnt_inc.s10 = 4'd0;
                if (cnt.m1 != 4'd9) begin
                    cnt_inc.m1 = cnt.m1 + 4'd1;
                end else begin
                    cnt_inc.m1  = 4'd0;
                    cnt_inc.m10 = (cnt.m10 == 4'd5) ? 4'd0 : cnt.m10 + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            running    <= 1'b0;
            lap_active <= 1'b0;
            cnt        <= '0;
            lap        <= '0;
            disp       <= '0;
        end else begin
            disp <= lap_active ? lap : cnt;

            if (tick) begin
                if (at_max && !WRAP_EN) begin
                    state   <= PAUSE;
                    running <= 1'b0;
                end else begin
                    cnt <= cnt_inc;
                end
            end

            // clear wins over start, start over lap; a clear in RUN still swallows the others
            if (sw.btn_clear) begin
                if (state != RUN) begin
                    state      <= IDLE;
                    running    <= 1'b0;
                    cnt        <= '0;
                    lap_active <= 1'b0;
                end
            end else if (sw.btn_start) begin
                if (state == RUN) begin
                    state   <= PAUSE;
                    running <= 1'b0;
                end else begin
                    state   <= RUN;
                    running <= 1'b1;
                end
            end else if (sw.btn_lap) begin
                if (lap_active) begin
                    lap_active <= 1'b0;
                end else if (state == RUN) begin
                    lap        <= cnt;
                    lap_active <= 1'b1;
                end
            end
        end
    end

    assign sw.min10      = disp.m10;
    assign sw.min1       = disp.m1;
    assign sw.sec10      = disp.s10;
    assign sw.sec1       = disp.s1;
    assign sw.running    = running;
    assign sw.lap_active = lap_active;
endmodule

// File: tb/tb_stopwatch_mmss.sv
// Bench for stopwatch_mmss: a wrapping and a saturating instance share stimulus
// and are compared against a seconds-based reference model plus directed scenarios.
module tb_stopwatch_mmss;
    logic clk = 1'b0;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    stopwatch_mmss_if sw0 ();
    stopwatch_mmss_if sw1 ();

    stopwatch_mmss #(.WRAP_EN(1'b1)) dut0 (.clk(clk), .reset_n(reset_n), .sw(sw0));
    stopwatch_mmss #(.WRAP_EN(1'b0)) dut1 (.clk(clk), .reset_n(reset_n), .sw(sw1));

    always #5 clk = ~clk;

    // reference model in whole seconds; index 0 wraps, index 1 saturates
    int m_secs [2];
    int m_lap  [2];
    int m_disp [2];
    int m_st   [2];   // 0 idle, 1 run, 2 pause
    bit m_lapact [2];

    function automatic int dsec(input int i);
        int a, b, c, d;
        if (i == 0) begin
            a = int'(sw0.min10); b = int'(sw0.min1); c = int'(sw0.sec10); d = int'(sw0.sec1);
        end else begin
            a = int'(sw1.min10); b = int'(sw1.min1); c = int'(sw1.sec10); d = int'(sw1.sec1);
        end
        if (a > 5 || b > 9 || c > 5 || d > 9) return -1;
        return a * 600 + b * 60 + c * 10 + d;
    endfunction

    function automatic bit drun(input int i);
        return (i == 0) ? sw0.running : sw1.running;
    endfunction

    function automatic bit dlap(input int i);
        return (i == 0) ? sw0.lap_active : sw1.lap_active;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_secs[i] = 0; m_lap[i] = 0; m_disp[i] = 0; m_st[i] = 0; m_lapact[i] = 1'b0;
        end
    endtask

    task automatic model_step(input bit s, input bit st, input bit lp, input bit cl);
        for (int i = 0; i < 2; i++) begin
            int nd, ss, old;
            nd  = m_lapact[i] ? m_lap[i] : m_secs[i];
            ss  = m_st[i];
            old = m_secs[i];
            if (s && ss == 1) begin
                if (old == 3599 && i == 1) m_st[i] = 2;
                else m_secs[i] = (old + 1) % 3600;
            end
            if (cl) begin
                if (ss != 1) begin
                    m_st[i] = 0; m_secs[i] = 0; m_lapact[i] = 1'b0;
                end
            end else if (st) begin
                m_st[i] = (ss == 1) ? 2 : 1;
            end else if (lp) begin
                if (m_lapact[i]) m_lapact[i] = 1'b0;
                else if (ss == 1) begin
                    m_lap[i] = old; m_lapact[i] = 1'b1;
                end
            end
            m_disp[i] = nd;
        end
    endtask

    // one clock of stimulus; returns #1 after the edge with pulses dropped
    task automatic cyc(input bit s, input bit st, input bit lp, input bit cl);
        sw0.clk_sec = s; sw0.btn_start = st; sw0.btn_lap = lp; sw0.btn_clear = cl;
        sw1.clk_sec = s; sw1.btn_start = st; sw1.btn_lap = lp; sw1.btn_clear = cl;
        @(posedge clk);
        model_step(s, st, lp, cl);
        #1;
        sw0.clk_sec = 0; sw0.btn_start = 0; sw0.btn_lap = 0; sw0.btn_clear = 0;
        sw1.clk_sec = 0; sw1.btn_start = 0; sw1.btn_lap = 0; sw1.btn_clear = 0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) cyc(1, 0, 0, 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        #1;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (dsec(i) !== 0) begin errors++; $display("FAIL reset_disp[%0d]: got %0d want 0", i, dsec(i)); end
            checks++;
            if (drun(i) !== 1'b0) begin errors++; $display("FAIL reset_running[%0d]: got %0b want 0", i, drun(i)); end
            checks++;
            if (dlap(i) !== 1'b0) begin errors++; $display("FAIL reset_lap[%0d]: got %0b want 0", i, dlap(i)); end
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_count_75();
        do_reset();
        cyc(0, 1, 0, 0);
        for (int k = 0; k < 75; k++) begin
            cyc(1, 0, 0, 0);
            if ($urandom_range(1, 0) == 1) cyc(0, 0, 0, 0);
        end
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (dsec(i) !== 75) begin errors++; $display("FAIL count75_disp[%0d]: got %0d want 75", i, dsec(i)); end
            checks++;
            if (drun(i) !== 1'b1) begin errors++; $display("FAIL count75_running[%0d]: got %0b want 1", i, drun(i)); end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        cyc(0, 1, 0, 0);
        ticks(599); cyc(0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (dsec(i) !== 599) begin errors++; $display("FAIL preload_0959[%0d]: got %0d want 599", i, dsec(i)); end
        end
        ticks(1); cyc(0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (dsec(i) !== 600) begin errors++; $display("FAIL carry_1000[%0d]: got %0d want 600", i, dsec(i)); end
        end
        ticks(2999); cyc(0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (dsec(i) !== 3599) begin errors++; $display("FAIL at_5959[%0d]: got %0d want 3599", i, dsec(i)); end
        end
        ticks(1); cyc(0, 0, 0, 0);
        checks++;
        if (dsec(0) !== 0) begin errors++; $display("FAIL wrap_disp: got %0d want 0", dsec(0)); end
        checks++;
        if (drun(0) !== 1'b1) begin errors++; $display("FAIL wrap_running: got %0b want 1", drun(0)); end
        checks++;
        if (dsec(1) !== 3599) begin errors++; $display("FAIL sat_disp: got %0d want 3599", dsec(1)); end
        checks++;
        if (drun(1) !== 1'b0) begin errors++; $display("FAIL sat_running: got %0b want 0", drun(1)); end
        ticks(2); cyc(0, 0, 0, 0);
        checks++;
        if (dsec(1) !== 3599) begin errors++; $display("FAIL sat_hold: got %0d want 3599", dsec(1)); end
        checks++;
        if (dsec(0) !== 2) begin errors++; $display("FAIL wrap_continue: got %0d want 2", dsec(0)); end
    endtask

    task automatic test_lap();
        do_reset();
        cyc(0, 1, 0, 0);
        ticks(42);
        cyc(0, 0, 1, 0); cyc(0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (dsec(i) !== 42) begin errors++; $display("FAIL lap_freeze[%0d]: got %0d want 42", i, dsec(i)); end
            checks++;
            if (dlap(i) !== 1'b1) begin errors++; $display("FAIL lap_set[%0d]: got %0b want 1", i, dlap(i)); end
        end
        ticks(10); cyc(0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (dsec(i) !== 42) begin errors++; $display("FAIL lap_hold[%0d]: got %0d want 42", i, dsec(i)); end
        end
        cyc(0, 0, 1, 0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (dlap(i) !== 1'b0) begin errors++; $display("FAIL lap_release[%0d]: got %0b want 0", i, dlap(i)); end
        end
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (dsec(i) !== 52) begin errors++; $display("FAIL lap_live[%0d]: got %0d want 52", i, dsec(i)); end
        end
    endtask

    task automatic test_clear();
        do_reset();
        cyc(0, 1, 0, 0);
        ticks(5);
        cyc(1, 0, 0, 1); cyc(0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (dsec(i) !== 6) begin errors++; $display("FAIL clear_in_run[%0d]: got %0d want 6", i, dsec(i)); end
            checks++;
            if (drun(i) !== 1'b1) begin errors++; $display("FAIL clear_in_run_running[%0d]: got %0b want 1", i, drun(i)); end
        end
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 1); cyc(0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (dsec(i) !== 0) begin errors++; $display("FAIL clear_pause[%0d]: got %0d want 0", i, dsec(i)); end
            checks++;
            if (drun(i) !== 1'b0) begin errors++; $display("FAIL clear_pause_running[%0d]: got %0b want 0", i, drun(i)); end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        cyc(0, 1, 0, 0);
        ticks(10);
        cyc(0, 0, 1, 0);
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (drun(i) !== 1'b0 || dlap(i) !== 1'b1) begin
                errors++; $display("FAIL simul_setup[%0d]: got run=%0b lap=%0b want run=0 lap=1", i, drun(i), dlap(i));
            end
        end
        cyc(1, 1, 1, 1); cyc(0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (dsec(i) !== 0) begin errors++; $display("FAIL simul_disp[%0d]: got %0d want 0", i, dsec(i)); end
            checks++;
            if (drun(i) !== 1'b0 || dlap(i) !== 1'b0) begin
                errors++; $display("FAIL simul_flags[%0d]: got run=%0b lap=%0b want 0 0", i, drun(i), dlap(i));
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        cyc(0, 1, 0, 0);
        ticks(207); cyc(0, 0, 0, 0);
        checks++;
        if (dsec(0) !== 207) begin errors++; $display("FAIL pre_reset_0327: got %0d want 207", dsec(0)); end
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (dsec(i) !== 0 || drun(i) !== 1'b0 || dlap(i) !== 1'b0) begin
                errors++; $display("FAIL async_reset[%0d]: got disp=%0d run=%0b lap=%0b want 0 0 0", i, dsec(i), drun(i), dlap(i));
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
        ticks(5); cyc(0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (dsec(i) !== 0 || drun(i) !== 1'b0) begin
                errors++; $display("FAIL post_reset_idle[%0d]: got disp=%0d run=%0b want 0 0", i, dsec(i), drun(i));
            end
        end
        cyc(0, 1, 0, 0); ticks(1); cyc(0, 0, 0, 0);
        checks++;
        if (dsec(0) !== 1) begin errors++; $display("FAIL post_reset_start: got %0d want 1", dsec(0)); end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 2500; k++) begin
            bit s, st, lp, cl;
            s  = ($urandom_range(2, 0) == 0);
            st = ($urandom_range(39, 0) == 0);
            lp = ($urandom_range(24, 0) == 0);
            cl = ($urandom_range(59, 0) == 0);
            cyc(s, st, lp, cl);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (dsec(i) !== m_disp[i] || drun(i) !== (m_st[i] == 1) || dlap(i) !== m_lapact[i]) begin
                    errors++;
                    $display("FAIL random[%0d] cyc %0d: got disp=%0d run=%0b lap=%0b want disp=%0d run=%0b lap=%0b",
                             i, k, dsec(i), drun(i), dlap(i), m_disp[i], (m_st[i] == 1), m_lapact[i]);
                end
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        sw0.clk_sec = 0; sw0.btn_start = 0; sw0.btn_lap = 0; sw0.btn_clear = 0;
        sw1.clk_sec = 0; sw1.btn_start = 0; sw1.btn_lap = 0; sw1.btn_clear = 0;
        model_reset();
        test_reset();
        test_count_75();
        test_wrap();
        test_lap();
        test_clear();
        test_simultaneous();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
